// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and access sequencer.
// Optional grant counters are enabled with MEM_ARBITER_STATS_EN.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic          byte0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic          byte1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
`ifdef MEM_ARBITER_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1,
`endif
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_we_byte,
  output logic          mem_we_word,
  output logic          mem_out_byte,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          prio;
  logic          grant;
  logic          win;
  logic          cmd_id;
  logic          cmd_we;
  logic          cmd_byte;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] rdata_q;
  logic          acc;
  logic          done;

  // Next state and winner selection
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = prio;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          win       = (req0 && req1) ? prio : req1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, priority pointer, command latch and read data register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_byte  <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        prio      <= ~win;
        cmd_id    <= win;
        cmd_we    <= win ? we1    : we0;
        cmd_byte  <= win ? byte1  : byte0;
        cmd_addr  <= win ? addr1  : addr0;
        cmd_wdata <= win ? wdata1 : wdata0;
      end
      if (acc && !cmd_we) begin
        rdata_q <= mem_data_out;
      end
    end
  end

  assign acc  = (state == ACCESS);
  assign done = (state == DONE);

  // Strobes are killed by reset so an in-flight write never commits
  assign mem_we_word  = acc & cmd_we & ~cmd_byte & ~reset;
  assign mem_we_byte  = acc & cmd_we & cmd_byte & ~reset;
  assign mem_out_byte = acc & ~cmd_we & cmd_byte & ~reset;
  assign mem_address  = cmd_addr;
  assign mem_data_in  = cmd_wdata;

  assign ack0  = done & ~cmd_id & ~reset;
  assign ack1  = done & cmd_id & ~reset;
  assign busy  = (state != IDLE);
  assign rdata = rdata_q;

`ifdef MEM_ARBITER_STATS_EN
  // Saturating per-requester grant counters; clear beats a grant
  always_ff @(posedge CLK) begin
    if (reset || stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (grant) begin
      if (!win && grant_cnt0 != 16'hFFFF) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (win && grant_cnt1 != 16'hFFFF) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// Reference model: word array plus grant-order queue.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, byte0, req1, we1, byte1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [31:0] rdata;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_we_byte, mem_we_word, mem_out_byte;
`ifdef MEM_ARBITER_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .CLK(clk), .reset(reset),
    .req0(req0), .we0(we0), .byte0(byte0), .addr0(addr0),
    .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .byte1(byte1), .addr1(addr1),
    .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
`ifdef MEM_ARBITER_STATS_EN
    .stats_clr(stats_clr), .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
`endif
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we_byte(mem_we_byte), .mem_we_word(mem_we_word),
    .mem_out_byte(mem_out_byte), .mem_data_out(mem_data_out)
  );

  // Data memory: synchronous write, combinational read
  logic [31:0] mem [256] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we_word) mem[mem_address] <= mem_data_in;
    if (mem_we_byte) mem[mem_address][7:0] <= mem_data_in[7:0];
  end
  assign mem_data_out = mem_out_byte ?
    {24'h0, mem[mem_address][7:0]} : mem[mem_address];

  typedef struct {
    int          id;
    logic        we;
    logic        byt;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
  } txn_t;

  logic [31:0] ref_mem [256] = '{default: 32'h0};
  txn_t eq0[$];
  txn_t eq1[$];
  int   gq[$];
  int   mprio = 0;
  int   gcnt[2] = '{0, 0};
  logic [31:0] last_rd = 32'h0;
  bit   cont_on = 1'b0;
  int   cont_id[$];
  int   cont_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic r, input logic w,
                       input logic b, input logic [7:0] a,
                       input logic [31:0] d);
    if (id == 0) begin
      req0 = r; we0 = w; byte0 = b; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; byte1 = b; addr1 = a; wdata1 = d;
    end
  endtask

  // Issue one access; caller is positioned just after a posedge
  task automatic do_txn(input int id, input logic w, input logic b,
                        input logic [7:0] a, input logic [31:0] d);
    txn_t t;
    bit   got;
    t.id = id; t.we = w; t.byt = b; t.a = a; t.d = d; t.rd = 32'h0;
    if (w) begin
      if (b) ref_mem[a][7:0] = d[7:0];
      else   ref_mem[a] = d;
    end else begin
      t.rd = b ? {24'h0, ref_mem[a][7:0]} : ref_mem[a];
    end
    if (id == 0) eq0.push_back(t);
    else         eq1.push_back(t);
    drive(id, 1'b1, w, b, a, d);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (id == 0) ? ack0 : ack1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout id=%0d act=0 exp=1", id);
    end
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_rand(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      do_txn(id, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {id[0], 7'($urandom_range(0, 7))}, $urandom);
    end
  endtask

  // Monitor: grant model, strobe snapshot and ack scoreboard
  logic        prev_busy = 1'b0;
  int          cyc = 0;
  int          acc_cyc = -10;
  logic [7:0]  s_addr;
  logic [31:0] s_din;
  logic        s_wew, s_web, s_ob;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      gq.delete(); eq0.delete(); eq1.delete();
      mprio = 0; last_rd = 32'h0; prev_busy = 1'b0;
      gcnt[0] = 0; gcnt[1] = 0;
    end else begin
      if (busy && !prev_busy) begin
        acc_cyc = cyc; s_addr = mem_address; s_din = mem_data_in;
        s_wew = mem_we_word; s_web = mem_we_byte; s_ob = mem_out_byte;
      end else begin
        chk("strobe_outside_access",
            32'({mem_we_word, mem_we_byte, mem_out_byte}), 32'h0);
      end
      if (ack0 || ack1) begin
        int   id;
        txn_t e;
        id = ack1 ? 1 : 0;
        chk("ack_both_high", 32'(ack0 && ack1), 32'h0);
        if (gq.size() == 0) begin
          chk("ack_unexpected", 32'(id), 32'hFFFF_FFFF);
        end else begin
          chk("ack_winner", 32'(id), 32'(gq.pop_front()));
        end
        if ((id == 0 && eq0.size() != 0) ||
            (id == 1 && eq1.size() != 0)) begin
          e = (id == 0) ? eq0.pop_front() : eq1.pop_front();
          chk("ack_latency", 32'(acc_cyc), 32'(cyc - 1));
          chk("acc_addr", 32'(s_addr), 32'(e.a));
          chk("acc_we_word", 32'(s_wew), 32'(e.we & ~e.byt));
          chk("acc_we_byte", 32'(s_web), 32'(e.we & e.byt));
          chk("acc_out_byte", 32'(s_ob), 32'(~e.we & e.byt));
          chk("done_addr_hold", 32'(mem_address), 32'(e.a));
          if (e.we) begin
            chk("acc_wdata", s_din, e.d);
            chk("rdata_hold_on_write", rdata, last_rd);
          end else begin
            chk("rdata", rdata, e.rd);
            last_rd = e.rd;
          end
        end
        if (cont_on) begin
          cont_id.push_back(id);
          cont_cyc.push_back(cyc);
        end
      end
      if (!busy && (req0 || req1)) begin
        int w;
        w = (req0 && req1) ? mprio : (req1 ? 1 : 0);
        gq.push_back(w);
        mprio = 1 - w;
        if (gcnt[w] < 65535) gcnt[w]++;
      end
`ifdef MEM_ARBITER_STATS_EN
      if (stats_clr) begin gcnt[0] = 0; gcnt[1] = 0; end
`endif
      prev_busy = busy;
    end
  end

  task automatic chk_reset_state();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_acks", 32'({ack0, ack1}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_strobes",
        32'({mem_we_word, mem_we_byte, mem_out_byte}), 32'h0);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
`ifdef MEM_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk); #1;

    do_txn(0, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
    do_txn(0, 1'b0, 1'b0, 8'h10, 32'h0);
    do_txn(1, 1'b1, 1'b1, 8'h20, 32'h123456AB);
    do_txn(1, 1'b0, 1'b0, 8'h20, 32'h0);
    do_txn(1, 1'b0, 1'b1, 8'h20, 32'h0);

    drive(0, 1'b1, 1'b1, 1'b0, 8'h30, 32'hFFFFFFFF);
    @(posedge clk);
    @(negedge clk); #2;
    chk("pre_reset_we_word", 32'(mem_we_word), 32'h1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    #1 chk("reset_kills_we_word", 32'(mem_we_word), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ack_after_reset", 32'({ack0, ack1, busy}), 32'h0);
    end
    @(posedge clk); #1;
    do_txn(0, 1'b0, 1'b0, 8'h30, 32'h0);

    do_reset();
    cont_on = 1'b1;
    fork
      for (int i = 0; i < 4; i++)
        do_txn(0, 1'(i % 2 == 0), 1'b0, 8'h40 + 8'(i / 2), $urandom);
      for (int i = 0; i < 4; i++)
        do_txn(1, 1'(i % 2 == 0), 1'b0, 8'hC0 + 8'(i / 2), $urandom);
    join
    cont_on = 1'b0;
    chk("cont_ack_count", 32'(cont_id.size()), 32'd8);
    for (int i = 0; i < cont_id.size(); i++) begin
      chk("cont_order", 32'(cont_id[i]), 32'(i % 2));
      if (i > 0)
        chk("cont_spacing", 32'(cont_cyc[i] - cont_cyc[i-1]), 32'd3);
    end

    fork
      run_rand(0, 25);
      run_rand(1, 25);
    join

`ifdef MEM_ARBITER_STATS_EN
    @(negedge clk);
    chk("cnt0_model", 32'(grant_cnt0), 32'(gcnt[0]));
    chk("cnt1_model", 32'(grant_cnt1), 32'(gcnt[1]));
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 5; i++) do_txn(0, 1'b0, 1'b0, 8'h01, 32'h0);
    for (int i = 0; i < 2; i++) do_txn(1, 1'b0, 1'b0, 8'h81, 32'h0);
    @(negedge clk);
    chk("grant_cnt0", 32'(grant_cnt0), 32'd5);
    chk("grant_cnt1", 32'(grant_cnt1), 32'd2);
    @(posedge clk); #1 stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt0", 32'(grant_cnt0), 32'h0);
    chk("clr_cnt1", 32'(grant_cnt1), 32'h0);
`endif

    repeat (4) @(negedge clk);
    chk("grants_left", 32'(gq.size()), 32'h0);
    chk("exp_left", 32'(eq0.size() + eq1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
